// File: rtl/vx_bitmask_gen_if.sv
// Element-in / mask-out handshake bundle for vx_bitmask_gen.
// The slave modport is the decoder; the master modport is the producer/consumer side.
interface vx_bitmask_gen_if #(
    parameter int N    = 2,
    parameter int LOGN = $clog2(N)
);
    logic            valid_in;
    logic [LOGN-1:0] cnt_in;
    logic            zero_in;
    logic            last_in;
    logic            ready_in;
    logic            valid_out;
    logic [N-1:0]    data_out;
    logic [LOGN:0]   count_out;
    logic            dup_out;
    logic            ready_out;

    modport slave (
        input  valid_in, cnt_in, zero_in, last_in, ready_out,
        output ready_in, valid_out, data_out, count_out, dup_out
    );

    modport master (
        output valid_in, cnt_in, zero_in, last_in, ready_out,
        input  ready_in, valid_out, data_out, count_out, dup_out
    );
endinterface

// File: rtl/vx_bitmask_gen.sv
// Sequential index-to-mask decoder: ORs decoded one-hot bits into a mask until a last element.
// Optional duplicate-bit detection is enabled by defining VX_BITMASK_GEN_DUP_CHECK_EN.
module vx_bitmask_gen #(
    parameter int N    = 2,
    parameter int MODE = 0,
    parameter int LOGN = $clog2(N)
) (
    input logic             clk,
    input logic             reset,
    vx_bitmask_gen_if.slave bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [LOGN:0] COUNT_MAX = '1;

    state_t        state, state_next;
    logic [N-1:0]  mask;
    logic [LOGN:0] count;
    logic [N-1:0]  bit_vec;
    logic          accept;
    logic          release_grp;

    // Indices that map outside [0, N) match no lane and are dropped.
    always_comb begin
        bit_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (!bus.zero_in && int'(bus.cnt_in) == ((MODE != 0) ? (N - 1 - i) : i))
                bit_vec[i] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        bus.ready_in  = 1'b0;
        bus.valid_out = 1'b0;
        accept        = 1'b0;
        release_grp   = 1'b0;
        case (state)
            ACCUM: begin
                bus.ready_in = 1'b1;
                accept       = bus.valid_in;
                if (bus.valid_in && bus.last_in) state_next = HOLD;
            end
            HOLD: begin
                bus.valid_out = 1'b1;
                release_grp   = bus.ready_out;
                if (bus.ready_out) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    // NOTE: reset is synchronous; clearing on reset or on release keeps partial groups from leaking.
    always_ff @(posedge clk) begin
        if (reset || release_grp) begin
            mask  <= '0;
            count <= '0;
        end else if (accept) begin
            mask <= mask | bit_vec;
            if (count != COUNT_MAX) count <= count + (LOGN+1)'(1);
        end
    end

    assign bus.data_out  = mask;
    assign bus.count_out = count;

`ifdef VX_BITMASK_GEN_DUP_CHECK_EN
    logic dup;

    // Sticky for the group; an empty bit_vec can never collide.
    always_ff @(posedge clk) begin
        if (reset || release_grp)             dup <= 1'b0;
        else if (accept && |(bit_vec & mask)) dup <= 1'b1;
    end

    assign bus.dup_out = dup;
`else
    assign bus.dup_out = 1'b0;
`endif

endmodule

// File: tb/tb_vx_bitmask_gen.sv
// Directed bench: three decoders (N=8/MODE=0, N=8/MODE=1, N=6/MODE=0) driven in lockstep.
module tb_vx_bitmask_gen;
    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [2:0] cnt_in;
    logic       zero_in;
    logic       last_in;
    logic       ready_out;

    int checks = 0;
    int errors = 0;

`ifdef VX_BITMASK_GEN_DUP_CHECK_EN
    localparam logic DUP_EN = 1'b1;
`else
    localparam logic DUP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    vx_bitmask_gen_if #(.N(8)) ifa ();
    vx_bitmask_gen_if #(.N(8)) ifb ();
    vx_bitmask_gen_if #(.N(6)) ifc ();

    assign ifa.valid_in = valid_in;  assign ifb.valid_in = valid_in;  assign ifc.valid_in = valid_in;
    assign ifa.cnt_in   = cnt_in;    assign ifb.cnt_in   = cnt_in;    assign ifc.cnt_in   = cnt_in;
    assign ifa.zero_in  = zero_in;   assign ifb.zero_in  = zero_in;   assign ifc.zero_in  = zero_in;
    assign ifa.last_in  = last_in;   assign ifb.last_in  = last_in;   assign ifc.last_in  = last_in;
    assign ifa.ready_out = ready_out; assign ifb.ready_out = ready_out; assign ifc.ready_out = ready_out;

    vx_bitmask_gen #(.N(8), .MODE(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    vx_bitmask_gen #(.N(8), .MODE(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    vx_bitmask_gen #(.N(6), .MODE(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    typedef struct {
        logic [2:0] cnt;
        logic       zero;
        logic       last;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [5:0] exp_c;
        logic [3:0] exp_cnt;
        logic       exp_dup;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] cnt, input logic zero, input logic last,
                                input logic [7:0] ea, input logic [7:0] eb, input logic [5:0] ec,
                                input logic [3:0] en, input logic ed);
        vec_t v;
        v.cnt = cnt; v.zero = zero; v.last = last;
        v.exp_a = ea; v.exp_b = eb; v.exp_c = ec; v.exp_cnt = en; v.exp_dup = ed;
        return v;
    endfunction

    // Present one element and hold it until accepted, bounded by a cycle budget.
    task automatic send(input logic [2:0] cnt, input logic zero, input logic last);
        bit taken = 1'b0;
        @(negedge clk);
        valid_in = 1'b1; cnt_in = cnt; zero_in = zero; last_in = last;
        for (int w = 0; w < 20; w++) begin
            if (ifa.ready_in) begin taken = 1'b1; break; end
            @(negedge clk);
        end
        if (!taken) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready_in stayed 0 for 20 cycles");
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0; last_in = 1'b0; zero_in = 1'b0;
    endtask

    task automatic check_group(input logic [7:0] ea, input logic [7:0] eb, input logic [5:0] ec,
                               input logic [3:0] en, input logic ed);
        check("valid_out_a", ifa.valid_out, 1);
        check("valid_out_b", ifb.valid_out, 1);
        check("valid_out_c", ifc.valid_out, 1);
        check("ready_in_hold", ifa.ready_in, 0);
        check("data_out_a", ifa.data_out, ea);
        check("data_out_b", ifb.data_out, eb);
        check("data_out_c", ifc.data_out, ec);
        check("count_out_a", ifa.count_out, en);
        check("count_out_c", ifc.count_out, en);
        check("dup_out_a", ifa.dup_out, ed);
    endtask

    task automatic consume();
        @(negedge clk);
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        check("valid_out_after_hs", ifa.valid_out, 0);
        check("ready_in_after_hs", ifa.ready_in, 1);
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; cnt_in = '0; zero_in = 1'b0; last_in = 1'b0; ready_out = 1'b0;

        // Groups: elements in order, expectations carried on the last element.
        vecs.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3'd3, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3'd6, 0, 1, 8'h4A, 8'h52, 6'h0A, 4'd3, 1'b0));
        vecs.push_back(mk(3'd0, 0, 1, 8'h01, 8'h80, 6'h01, 4'd1, 1'b0));
        vecs.push_back(mk(3'd0, 1, 1, 8'h00, 8'h00, 6'h00, 4'd1, 1'b0));
        vecs.push_back(mk(3'd7, 0, 1, 8'h80, 8'h01, 6'h00, 4'd1, 1'b0));
        vecs.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3'd2, 0, 1, 8'h04, 8'h20, 6'h04, 4'd2, DUP_EN));
        vecs.push_back(mk(3'd5, 0, 1, 8'h20, 8'h04, 6'h20, 4'd1, 1'b0));
        vecs.push_back(mk(3'd0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3'd4, 0, 1, 8'h10, 8'h08, 6'h10, 4'd2, 1'b0));
        // Sixteen elements: count saturates at 15, every lane covered, repeats flag dup.
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(3'(i % 8), 0, (i == 15), 8'hFF, 8'hFF, 6'h3F, 4'd15, DUP_EN));

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", ifa.valid_out, 0);
        check("rst_ready_in", ifa.ready_in, 1);
        check("rst_data_out", ifa.data_out, 0);
        check("rst_count_out", ifa.count_out, 0);
        check("rst_dup_out", ifa.dup_out, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) begin
            send(vecs[k].cnt, vecs[k].zero, vecs[k].last);
            if (vecs[k].last) begin
                check_group(vecs[k].exp_a, vecs[k].exp_b, vecs[k].exp_c,
                            vecs[k].exp_cnt, vecs[k].exp_dup);
                consume();
            end
        end

        // Backpressure with valid_in held: HOLD must ignore the pending element.
        send(3'd2, 0, 1);
        @(negedge clk);
        valid_in = 1'b1; cnt_in = 3'd7; last_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_valid_out", ifa.valid_out, 1);
            check("bp_data_out", ifa.data_out, 8'h04);
            check("bp_count_out", ifa.count_out, 1);
            check("bp_ready_in", ifa.ready_in, 0);
        end
        valid_in = 1'b0; last_in = 1'b0;
        consume();
        send(3'd0, 0, 1);
        check_group(8'h01, 8'h80, 6'h01, 4'd1, 1'b0);
        consume();

        // Reset mid-group discards the partial group.
        send(3'd5, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_valid_out", ifa.valid_out, 0);
        check("midrst_data_out", ifa.data_out, 0);
        check("midrst_count_out", ifa.count_out, 0);
        check("midrst_dup_out", ifa.dup_out, 0);
        check("midrst_ready_in", ifa.ready_in, 1);
        send(3'd1, 0, 1);
        check_group(8'h02, 8'h40, 6'h02, 4'd1, 1'b0);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
